data_mem_responder: RTL

- Memory-side responder for the multicycle RV32I core's load/store states.
- Accepts one request at a time over a req/ready/ack handshake and inserts a programmable number of wait states.
- Performs little-endian byte/half/word reads and writes into an internal word-organised RAM, sign- or zero-extending load data.
- Flags misaligned, out-of-range or illegal-size accesses with an error instead of touching memory.

---
 rtl/data_mem_responder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Memory-side responder for the multicycle RV32I core: one request at a time,
// programmable wait states, little-endian byte/half/word access to a word RAM.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic        mem_ack,
    output logic        mem_err,
    output logic [31:0] mem_rdata
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // The WAIT state spans WAIT_CYCLES edges including the commit edge.
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        commit;

    logic        we_p0, uns_p0;
    logic [1:0]  size_p0;
    logic [31:0] addr_p0, wdata_p0;

    logic        cur_we, cur_uns, cur_err;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr, cur_wdata;
    logic [AW-1:0] cur_idx;
    logic [3:0]  be;
    logic [31:0] wd;

    logic [31:0] ram [DEPTH_WORDS];

    function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
        logic oor;
        oor = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
        return (size == 2'b11) | ((size == 2'b01) & addr[0]) |
               ((size == 2'b10) & (addr[1:0] != 2'b00)) | oor;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? 32'({8'b0, b}) : 32'(b);
            2'b01:   r = uns ? 32'({16'b0, h}) : 32'(h);
            default: r = word;
        endcase
        return r;
    endfunction

    // At the acceptance edge the live inputs are the request; afterwards the latched copy.
    always_comb begin
        if (state == ST_IDLE) begin
            cur_we    = mem_we;
            cur_size  = mem_size;
            cur_uns   = mem_unsigned;
            cur_addr  = mem_addr;
            cur_wdata = mem_wdata;
        end else begin
            cur_we    = we_p0;
            cur_size  = size_p0;
            cur_uns   = uns_p0;
            cur_addr  = addr_p0;
            cur_wdata = wdata_p0;
        end
        cur_err = access_err(cur_size, cur_addr);
        cur_idx = cur_addr[AW+1:2];
    end

    always_comb begin
        be = 4'b0000;
        wd = cur_wdata;
        case (cur_size)
            2'b00: begin
                be = 4'b0001 << cur_addr[1:0];
                wd = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be = cur_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{cur_wdata[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        mem_ready = 1'b0;
        mem_ack   = 1'b0;
        case (state)
            ST_IDLE: begin
                mem_ready = 1'b1;
                if (mem_req) begin
                    if (NO_WAIT) begin
                        commit    = 1'b1;
                        state_nxt = ST_ACK;
                    end else begin
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = ST_ACK;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_ACK: begin
                mem_ack   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            mem_err   <= 1'b0;
            mem_rdata <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (commit) begin
                mem_err <= cur_err;
                if (cur_err || cur_we)
                    mem_rdata <= 32'd0;
                else
                    mem_rdata <= load_extend(ram[cur_idx], cur_size, cur_addr[1:0], cur_uns);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && mem_req) begin
            we_p0    <= mem_we;
            size_p0  <= mem_size;
            uns_p0   <= mem_unsigned;
            addr_p0  <= mem_addr;
            wdata_p0 <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && cur_we && !cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    ram[cur_idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

endmodule
